pe_feeder: RTL and testbench

PE_FEEDER -- requirements
Module: pe_feeder

---
 rtl/pe_feeder.sv | 171 +++++++++++++++++
 tb/tb_pe_feeder.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_feeder.sv
// Sample-history / tap sequencer that feeds one multiply-accumulate PE, one pair per cycle.
// Optional feature: define PE_FEEDER_FLUSH_EN to add the flush input (clears history in IDLE).
module pe_feeder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_TAPS   = 11,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tap_we,
    input  logic [ADDR_WIDTH-1:0] tap_addr,
    input  logic [DATA_WIDTH-1:0] tap_wdata,
`ifdef PE_FEEDER_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [DATA_WIDTH-1:0] o_tap,
    output logic                  o_sample_done,
    output logic                  busy,
    output logic                  tap_err
);

    localparam int unsigned AW1 = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0]   TAPS_EXT = AW1'(NUM_TAPS);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] tap_q  [NUM_TAPS];
    logic [DATA_WIDTH-1:0] tap_d  [NUM_TAPS];
    logic [DATA_WIDTH-1:0] hist_q [NUM_TAPS];
    logic [DATA_WIDTH-1:0] hist_d [NUM_TAPS];
    logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
    logic [DATA_WIDTH-1:0] o_tap_q, o_tap_d;
    logic                  done_q, done_d;
    logic                  tap_err_q, tap_err_d;

    logic                  flush_req;
    logic                  addr_ok;
    logic                  accept;
    logic [ADDR_WIDTH-1:0] next_idx;
    logic [DATA_WIDTH-1:0] nxt_data;
    logic [DATA_WIDTH-1:0] nxt_tap;

`ifdef PE_FEEDER_FLUSH_EN
    assign flush_req = flush;
`else
    assign flush_req = 1'b0;
`endif

    // Ready is forced low during reset and while a flush owns the IDLE cycle.
    assign s_ready  = rst_n && (state_q == IDLE) && !flush_req;
    assign accept   = s_valid && s_ready;
    assign addr_ok  = ({1'b0, tap_addr} < TAPS_EXT);
    assign next_idx = idx_q + ADDR_WIDTH'(1);

    // Operand pair for the following index, selected without a wide array index.
    always_comb begin
        nxt_data = '0;
        nxt_tap  = '0;
        for (int k = 0; k < NUM_TAPS; k++) begin
            if (next_idx == ADDR_WIDTH'(k)) begin
                nxt_data = hist_q[k];
                nxt_tap  = tap_q[k];
            end
        end
    end

    // Next-state, history/tap update and registered operand generation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        tap_d     = tap_q;
        hist_d    = hist_q;
        o_data_d  = '0;
        o_tap_d   = '0;
        done_d    = 1'b0;
        tap_err_d = tap_err_q;

        if (tap_we && (state_q != IDLE)) begin
            tap_err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tap_we && addr_ok) begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        if (tap_addr == ADDR_WIDTH'(k)) begin
                            tap_d[k] = tap_wdata;
                        end
                    end
                end
                if (flush_req) begin
                    for (int k = 0; k < NUM_TAPS; k++) begin
                        hist_d[k] = '0;
                    end
                end else if (accept) begin
                    hist_d[0] = s_data;
                    for (int k = 1; k < NUM_TAPS; k++) begin
                        hist_d[k] = hist_q[k-1];
                    end
                    state_d  = FEED;
                    idx_d    = '0;
                    // First pair leaves with the acceptance edge; tap_d carries a coincident write.
                    o_data_d = s_data;
                    o_tap_d  = tap_d[0];
                end
            end
            FEED: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d    = next_idx;
                    o_data_d = nxt_data;
                    o_tap_d  = nxt_tap;
                end
            end
            DRAIN: begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            o_data_q  <= '0;
            o_tap_q   <= '0;
            done_q    <= 1'b0;
            tap_err_q <= 1'b0;
            for (int k = 0; k < NUM_TAPS; k++) begin
                tap_q[k]  <= '0;
                hist_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            o_data_q  <= o_data_d;
            o_tap_q   <= o_tap_d;
            done_q    <= done_d;
            tap_err_q <= tap_err_d;
            for (int k = 0; k < NUM_TAPS; k++) begin
                tap_q[k]  <= tap_d[k];
                hist_q[k] <= hist_d[k];
            end
        end
    end

    assign o_data        = o_data_q;
    assign o_tap         = o_tap_q;
    assign o_sample_done = done_q;
    assign busy          = (state_q != IDLE);
    assign tap_err       = tap_err_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Self-checking bench for pe_feeder (NUM_TAPS=4): convolution reference model plus a PE accumulator.
module tb_pe_feeder;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tap_we;
    logic [2:0]  tap_addr;
    logic [31:0] tap_wdata;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic [31:0] o_data;
    logic [31:0] o_tap;
    logic        o_sample_done;
    logic        busy;
    logic        tap_err;
`ifdef PE_FEEDER_FLUSH_EN
    logic        flush;
`endif

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [31:0] ref_taps [N];
    logic [31:0] ref_hist [N];
    logic [31:0] exp_d [N];
    logic [31:0] exp_t [N];
    logic [31:0] ref_sum;
    logic [31:0] pe_acc;

    pe_feeder #(.DATA_WIDTH(32), .NUM_TAPS(N), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .tap_we(tap_we), .tap_addr(tap_addr), .tap_wdata(tap_wdata),
`ifdef PE_FEEDER_FLUSH_EN
        .flush(flush),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .o_data(o_data), .o_tap(o_tap), .o_sample_done(o_sample_done),
        .busy(busy), .tap_err(tap_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream PE: running accumulator of operand products, reset with the feeder.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pe_acc <= '0;
        else        pe_acc <= pe_acc + o_data * o_tap;
    end

    task automatic model_reset;
        for (int k = 0; k < N; k++) begin
            ref_taps[k] = '0;
            ref_hist[k] = '0;
        end
        ref_sum = '0;
    endtask

    task automatic model_tap_write(input logic [2:0] a, input logic [31:0] d);
        if (int'(a) < N) ref_taps[a[1:0]] = d;
    endtask

    // New sample enters the delay line; its pairs are history[k] * tap[k].
    task automatic model_accept(input logic [31:0] v);
        for (int k = N - 1; k > 0; k--) ref_hist[k] = ref_hist[k-1];
        ref_hist[0] = v;
        for (int k = 0; k < N; k++) begin
            exp_d[k] = ref_hist[k];
            exp_t[k] = ref_taps[k];
            ref_sum  = ref_sum + ref_hist[k] * ref_taps[k];
        end
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic write_tap(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        tap_we = 1'b1; tap_addr = a; tap_wdata = d;
        model_tap_write(a, d);
        @(negedge clk);
        tap_we = 1'b0;
    endtask

    task automatic load_taps_1234;
        for (int k = 0; k < N; k++) write_tap(3'(k), 32'(k + 1));
    endtask

    // One sample through the feeder with cycle-exact pair, done and accumulator checks.
    task automatic send_sample(input logic [31:0] v, input bit wr_en, input logic [2:0] wr_addr,
                               input logic [31:0] wr_data, input bit bad_wr);
        @(negedge clk);
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL send_ready: s_ready=%b required 1", s_ready);
        end
        s_valid = 1'b1; s_data = v;
        tap_we = wr_en; tap_addr = wr_addr; tap_wdata = wr_data;
        if (wr_en) model_tap_write(wr_addr, wr_data);
        model_accept(v);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            tap_we = bad_wr && (k == 1); tap_addr = 3'd0; tap_wdata = 32'd9;
            s_valid = 1'($urandom_range(0, 1)); s_data = $urandom;
            checks++;
            if (o_data !== exp_d[k] || o_tap !== exp_t[k]) begin
                failures++;
                $display("FAIL pair%0d: got (%0d,%0d) required (%0d,%0d)", k, o_data, o_tap, exp_d[k], exp_t[k]);
            end
            checks++;
            if (busy !== 1'b1 || s_ready !== 1'b0) begin
                failures++;
                $display("FAIL feed_flags%0d: busy=%b s_ready=%b required 1/0", k, busy, s_ready);
            end
        end
        @(negedge clk);
        tap_we = 1'b0; s_valid = 1'b0;
        checks++;
        if (o_data !== 32'd0 || o_tap !== 32'd0 || o_sample_done !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL drain: data=%0d tap=%0d done=%b busy=%b required 0/0/0/1", o_data, o_tap, o_sample_done, busy);
        end
        @(negedge clk);
        checks++;
        if (o_sample_done !== 1'b1 || s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done: done=%b s_ready=%b busy=%b required 1/1/0", o_sample_done, s_ready, busy);
        end
        checks++;
        if (pe_acc !== ref_sum) begin
            failures++;
            $display("FAIL pe_sum: got %0d required %0d", pe_acc, ref_sum);
        end
        if (bad_wr) begin
            checks++;
            if (tap_err !== 1'b1) begin
                failures++;
                $display("FAIL tap_err_set: got %b required 1", tap_err);
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; tap_we = 1'b0; tap_addr = '0; tap_wdata = '0;
        s_valid = 1'b1; s_data = 32'd77;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || o_data !== 32'd0 || o_tap !== 32'd0 ||
            o_sample_done !== 1'b0 || tap_err !== 1'b0) begin
            failures++;
            $display("FAIL in_reset: rdy=%b busy=%b data=%0d tap=%0d done=%b err=%b required all 0",
                     s_ready, busy, o_data, o_tap, o_sample_done, tap_err);
        end
        s_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++;
        if (s_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL post_reset: s_ready=%b busy=%b required 1/0", s_ready, busy);
        end
    endtask

    task automatic test_basic;
        load_taps_1234();
        send_sample(32'd5, 1'b0, 3'd0, 32'd0, 1'b0);
        checks++;
        if (pe_acc !== 32'd5) begin
            failures++;
            $display("FAIL sum_5: got %0d required 5", pe_acc);
        end
        send_sample(32'd6, 1'b0, 3'd0, 32'd0, 1'b0);
        checks++;
        if (pe_acc !== 32'd21) begin
            failures++;
            $display("FAIL sum_21: got %0d required 21", pe_acc);
        end
    endtask

    task automatic test_back_to_back;
        logic [31:0] vals [3];
        int acc_at [3];
        int n;
        bit found;
        vals = '{32'd1, 32'd2, 32'd3};
        n = 0;
        @(negedge clk);
        s_valid = 1'b1; s_data = vals[0];
        for (int c = 0; c < 40 && n < 3; c++) begin
            if (s_ready === 1'b1) begin
                acc_at[n] = cyc;
                if (n > 0) begin
                    checks++;
                    if (o_sample_done !== 1'b1) begin
                        failures++;
                        $display("FAIL b2b_done%0d: done=%b required 1", n, o_sample_done);
                    end
                end
                model_accept(vals[n]);
                n++;
            end
            @(negedge clk);
            if (n < 3) s_data = vals[n];
            else       s_valid = 1'b0;
        end
        s_valid = 1'b0;
        checks++;
        if (n != 3) begin
            failures++;
            $display("FAIL b2b_timeout: accepted %0d required 3", n);
        end
        for (int i = 1; i < 3 && i < n; i++) begin
            checks++;
            if (acc_at[i] - acc_at[i-1] != N + 2) begin
                failures++;
                $display("FAIL b2b_spacing%0d: got %0d required %0d", i, acc_at[i] - acc_at[i-1], N + 2);
            end
        end
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            if (o_sample_done === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL b2b_final_done: no pulse within 20 cycles");
        end
        checks++;
        if (pe_acc !== ref_sum) begin
            failures++;
            $display("FAIL b2b_sum: got %0d required %0d", pe_acc, ref_sum);
        end
    endtask

    task automatic test_tap_err;
        checks++;
        if (tap_err !== 1'b0) begin
            failures++;
            $display("FAIL tap_err_clear: got %b required 0", tap_err);
        end
        send_sample(32'd7, 1'b0, 3'd0, 32'd0, 1'b1);
        send_sample(32'd8, 1'b0, 3'd0, 32'd0, 1'b0);
        write_tap(3'd7, 32'hDEAD);
        checks++;
        if (tap_err !== 1'b1) begin
            failures++;
            $display("FAIL tap_err_sticky: got %b required 1", tap_err);
        end
        send_sample(32'd9, 1'b0, 3'd0, 32'd0, 1'b0);
    endtask

    task automatic test_coincide;
        send_sample(32'd11, 1'b1, 3'd0, 32'd77, 1'b0);
        send_sample(32'd12, 1'b1, 3'($urandom_range(0, 3)), $urandom, 1'b0);
    endtask

    task automatic test_random;
        for (int it = 0; it < 10; it++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            if ($urandom_range(0, 1) == 1) write_tap(3'($urandom_range(0, 7)), $urandom);
            send_sample($urandom, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom,
                        $urandom_range(0, 3) == 0);
        end
    endtask

    task automatic test_reset_abort;
        int pulses;
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'd13;
        @(negedge clk);
        s_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (o_data !== 32'd0 || o_tap !== 32'd0 || busy !== 1'b0 || s_ready !== 1'b0 || tap_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_reset: data=%0d tap=%0d busy=%b rdy=%b err=%b required 0",
                     o_data, o_tap, busy, s_ready, tap_err);
        end
        pulses = 0;
        repeat (2) begin
            @(negedge clk);
            if (o_sample_done === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            failures++;
            $display("FAIL abort_ready: s_ready=%b required 1", s_ready);
        end
        repeat (8) begin
            @(negedge clk);
            if (o_sample_done === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_no_done: saw %0d pulses required 0", pulses);
        end
        load_taps_1234();
        send_sample(32'd3, 1'b0, 3'd0, 32'd0, 1'b0);
    endtask

`ifdef PE_FEEDER_FLUSH_EN
    task automatic test_flush;
        do_reset();
        load_taps_1234();
        send_sample(32'd5, 1'b0, 3'd0, 32'd0, 1'b0);
        send_sample(32'd6, 1'b0, 3'd0, 32'd0, 1'b0);
        @(negedge clk);
        flush = 1'b1; s_valid = 1'b1; s_data = 32'd99;
        #1;
        checks++;
        if (s_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready: s_ready=%b required 0", s_ready);
        end
        @(negedge clk);
        flush = 1'b0; s_valid = 1'b0;
        for (int k = 0; k < N; k++) ref_hist[k] = '0;
        checks++;
        if (busy !== 1'b0 || o_data !== 32'd0) begin
            failures++;
            $display("FAIL flush_no_accept: busy=%b data=%0d required 0/0", busy, o_data);
        end
        send_sample(32'd2, 1'b0, 3'd0, 32'd0, 1'b0);
    endtask
`endif

    initial begin
`ifdef PE_FEEDER_FLUSH_EN
        flush = 1'b0;
`endif
        test_reset();
        test_basic();
        test_back_to_back();
        test_tap_err();
        test_coincide();
        test_random();
        test_reset_abort();
`ifdef PE_FEEDER_FLUSH_EN
        test_flush();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
